// File: rtl/xoodoo_ctrl_sca.sv
// xoodoo_ctrl_sca: command sequencer for the two-share (DOM) Xoodoo state
// register and the masked round datapath.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   cmd_*              command handshake: op (INIT/ABSORB/PERMUTE/SQUEEZE),
//                      word count, domain constant and domain-add enable
//   din_*              absorb word stream {share0, share1}
//   dout_*             squeeze word stream (pass-through of reg_word_out)
//   rnd_valid          fresh DOM randomness available for the current round
//   reg_*              control/data towards the state register
//   reg_word_out       word read back from the state register
//   round_idx          round constant select for the round function
//   busy, done         status: not idle / one-cycle completion pulse
module xoodoo_ctrl_sca #(
    parameter int unsigned ROUNDS = 12,
    parameter int unsigned NWORDS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_len,
    input  logic [31:0] cmd_domain,
    input  logic        cmd_dom_en,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [63:0] din,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [63:0] dout,
    input  logic        rnd_valid,
    output logic        reg_init,
    output logic        reg_en,
    output logic        reg_word_en,
    output logic [3:0]  reg_word_idx,
    output logic [63:0] reg_word_in,
    output logic        reg_dom_en,
    output logic [31:0] reg_domain,
    input  logic [63:0] reg_word_out,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAST_ROUND = CW'(ROUNDS - 1);
    localparam logic [CW-1:0] MAX_WORDS  = CW'(NWORDS);

    localparam logic [1:0] OP_INIT    = 2'd0;
    localparam logic [1:0] OP_ABSORB  = 2'd1;
    localparam logic [1:0] OP_PERMUTE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_ABSORB  = 3'd2,
        S_DOMAIN  = 3'd3,
        S_PERM    = 3'd4,
        S_SQUEEZE = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] wc;
    logic [CW-1:0] rc;
    logic [CW-1:0] len_eff;
    logic [31:0]   domain_q;
    logic          dom_en_q;
    logic          word_fire;
    logic          sq_fire;

    // State register, counters, captured command fields and done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            wc       <= '0;
            rc       <= '0;
            len_eff  <= '0;
            domain_q <= '0;
            dom_en_q <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state != S_IDLE) && (state_nx == S_IDLE);
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        domain_q <= cmd_domain;
                        dom_en_q <= cmd_dom_en;
                        len_eff  <= (cmd_len > MAX_WORDS) ? MAX_WORDS : cmd_len;
                        wc       <= '0;
                        rc       <= '0;
                    end
                end
                S_ABSORB:  if (word_fire)  wc <= wc + CW'(1);
                S_SQUEEZE: if (sq_fire)    wc <= wc + CW'(1);
                S_PERM:    if (rnd_valid)  rc <= rc + CW'(1);
                default: ;
            endcase
        end
    end

    // Next-state logic; streams finish on the cycle of their last transfer
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_INIT:    state_nx = S_INIT;
                        OP_ABSORB:  state_nx = S_ABSORB;
                        OP_PERMUTE: state_nx = S_PERM;
                        default:    state_nx = S_SQUEEZE;
                    endcase
                end
            end
            S_INIT:   state_nx = S_IDLE;
            S_ABSORB: begin
                if ((wc == len_eff) || (word_fire && (wc + CW'(1) == len_eff)))
                    state_nx = dom_en_q ? S_DOMAIN : S_IDLE;
            end
            S_DOMAIN: state_nx = S_IDLE;
            S_PERM: begin
                if (rnd_valid && (rc == LAST_ROUND))
                    state_nx = S_IDLE;
            end
            S_SQUEEZE: begin
                if ((wc == len_eff) || (sq_fire && (wc + CW'(1) == len_eff)))
                    state_nx = S_IDLE;
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    // Output decode; register strobes are mutually exclusive by state
    always_comb begin
        cmd_ready    = (state == S_IDLE);
        busy         = (state != S_IDLE);
        din_ready    = 1'b0;
        dout_valid   = 1'b0;
        dout         = '0;
        reg_init     = 1'b0;
        reg_en       = 1'b0;
        reg_word_en  = 1'b0;
        reg_word_idx = '0;
        reg_dom_en   = 1'b0;
        reg_domain   = '0;
        round_idx    = '0;
        case (state)
            S_INIT: reg_init = 1'b1;
            S_ABSORB: begin
                reg_word_idx = wc;
                din_ready    = (wc < len_eff);
                reg_word_en  = din_valid && (wc < len_eff);
            end
            S_DOMAIN: begin
                reg_dom_en = 1'b1;
                reg_domain = domain_q;
            end
            S_PERM: begin
                round_idx = rc;
                reg_en    = rnd_valid;
            end
            S_SQUEEZE: begin
                reg_word_idx = wc;
                dout_valid   = (wc < len_eff);
                dout         = reg_word_out;
            end
            default: ;
        endcase
    end

    assign word_fire   = reg_word_en;
    assign sq_fire     = dout_valid && dout_ready;
    assign reg_word_in = din;

endmodule

// File: tb/tb_xoodoo_ctrl_sca.sv
// tb_xoodoo_ctrl_sca: randomized self-checking bench for xoodoo_ctrl_sca.
module tb_xoodoo_ctrl_sca;

    localparam int ROUNDS = 12;
    localparam int NW     = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_dom_en;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_len;
    logic [31:0] cmd_domain;
    logic        din_valid, din_ready;
    logic [63:0] din;
    logic        dout_valid, dout_ready;
    logic [63:0] dout;
    logic        rnd_valid;
    logic        reg_init, reg_en, reg_word_en, reg_dom_en;
    logic [3:0]  reg_word_idx, round_idx;
    logic [63:0] reg_word_in, reg_word_out;
    logic [31:0] reg_domain;
    logic        busy, done;

    logic [63:0] mem [0:15];
    int errors = 0;
    int checks = 0;

    assign reg_word_out = mem[reg_word_idx];

    always #5 clk = ~clk;

    xoodoo_ctrl_sca #(.ROUNDS(ROUNDS), .NWORDS(NW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_domain(cmd_domain), .cmd_dom_en(cmd_dom_en),
        .din_valid(din_valid), .din_ready(din_ready), .din(din),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
        .rnd_valid(rnd_valid),
        .reg_init(reg_init), .reg_en(reg_en), .reg_word_en(reg_word_en),
        .reg_word_idx(reg_word_idx), .reg_word_in(reg_word_in),
        .reg_dom_en(reg_dom_en), .reg_domain(reg_domain),
        .reg_word_out(reg_word_out), .round_idx(round_idx),
        .busy(busy), .done(done)
    );

    task automatic issue(input logic [1:0] op, input logic [3:0] len,
                         input logic [31:0] dom, input logic den);
        @(negedge clk);
        cmd_op = op; cmd_len = len; cmd_domain = dom; cmd_dom_en = den;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if ({busy, done, reg_init, reg_en, reg_word_en, reg_dom_en, din_ready, dout_valid} !== 8'h00) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000000", {busy, done, reg_init, reg_en, reg_word_en, reg_dom_en, din_ready, dout_valid});
        end
        checks++; if ({reg_word_idx, round_idx, reg_domain, dout} !== '0) begin errors++; $display("FAIL reset_buses: got nonzero expected 0"); end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_release: got ready=%b busy=%b expected 1/0", cmd_ready, busy); end
    endtask

    task automatic test_init;
        int init_cnt = 0, init_cyc = -1, done_cyc = -1;
        logic rdy_at_done = 1'b0;
        issue(2'd0, 4'd0, 32'd0, 1'b0);
        for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
            @(negedge clk); #1;
            if (reg_init) begin init_cnt++; init_cyc = c; end
            if (done) begin done_cyc = c; rdy_at_done = cmd_ready; end
        end
        checks++; if (init_cnt != 1) begin errors++; $display("FAIL init_count: got %0d expected 1", init_cnt); end
        checks++; if (init_cyc != 1) begin errors++; $display("FAIL init_cycle: got %0d expected 1", init_cyc); end
        checks++; if (done_cyc != 2) begin errors++; $display("FAIL init_done_cycle: got %0d expected 2", done_cyc); end
        checks++; if (rdy_at_done !== 1'b1) begin errors++; $display("FAIL init_ready: got %b expected 1", rdy_at_done); end
        @(negedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL init_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_absorb(input logic [3:0] len, input logic den, input logic [31:0] dom,
                               input bit use_pat, input logic [15:0] vpat, input bit hold_cmd);
        int n = (int'(len) > NW) ? NW : int'(len);
        int wr = 0, dom_cnt = 0;
        bit done_seen = 0;
        issue(2'd1, len, dom, den);
        if (hold_cmd) begin cmd_op = 2'd2; cmd_valid = 1'b1; end
        for (int c = 0; c < 200 && !done_seen; c++) begin
            @(negedge clk);
            din_valid = use_pat ? ((c < 16) ? vpat[c] : 1'b1) : ($urandom_range(0, 2) != 0);
            din = {$urandom, $urandom};
            #1;
            checks++; if ($countones({reg_init, reg_en, reg_word_en, reg_dom_en}) > 1) begin errors++; $display("FAIL abs_exclusive: got %b expected onehot0", {reg_init, reg_en, reg_word_en, reg_dom_en}); end
            if (reg_word_in !== din) begin checks++; errors++; $display("FAIL abs_mirror: got %h expected %h", reg_word_in, din); end
            if (busy && wr < n) begin
                checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL abs_din_ready: got %b expected 1", din_ready); end
            end
            if (reg_word_en) begin
                checks++; if (!din_valid || wr >= n) begin errors++; $display("FAIL abs_strobe: got word_en valid=%b wr=%0d expected none", din_valid, wr); end
                checks++; if (reg_word_idx !== 4'(wr)) begin errors++; $display("FAIL abs_idx: got %0d expected %0d", reg_word_idx, wr); end
                wr++;
            end
            if (reg_dom_en) begin
                dom_cnt++;
                checks++; if (wr != n) begin errors++; $display("FAIL abs_dom_order: got %0d words expected %0d", wr, n); end
                checks++; if (reg_domain !== dom) begin errors++; $display("FAIL abs_domain: got %h expected %h", reg_domain, dom); end
            end
            if (hold_cmd && !done && cmd_ready) begin checks++; errors++; $display("FAIL abs_busy_accept: got ready=1 expected 0"); end
            if (done) begin done_seen = 1; cmd_valid = 1'b0; end
        end
        din_valid = 1'b0;
        checks++; if (wr != n) begin errors++; $display("FAIL abs_words: got %0d expected %0d", wr, n); end
        checks++; if (dom_cnt != (den ? 1 : 0)) begin errors++; $display("FAIL abs_dom_cnt: got %0d expected %0d", dom_cnt, den ? 1 : 0); end
        checks++; if (!done_seen) begin errors++; $display("FAIL abs_done: got 0 expected 1"); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abs_idle_after: got busy=%b expected 0", busy); end
    endtask

    task automatic test_permute(input bit use_pat, input int lo, input int hi);
        int loaded = 0, pulses = 0, exp_done = -1, done_cyc = -1;
        issue(2'd2, 4'd0, 32'd0, 1'b0);
        for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
            @(negedge clk);
            rnd_valid = use_pat ? !(c >= lo && c <= hi) : ($urandom_range(0, 3) != 0);
            #1;
            checks++; if ($countones({reg_init, reg_en, reg_word_en, reg_dom_en}) > 1) begin errors++; $display("FAIL perm_exclusive: got %b expected onehot0", {reg_init, reg_en, reg_word_en, reg_dom_en}); end
            if (reg_en) pulses++;
            if (loaded < ROUNDS) begin
                checks++; if (reg_en !== rnd_valid) begin errors++; $display("FAIL perm_reg_en: got %b expected %b", reg_en, rnd_valid); end
                checks++; if (round_idx !== 4'(loaded)) begin errors++; $display("FAIL perm_round_idx: got %0d expected %0d", round_idx, loaded); end
                if (rnd_valid) begin
                    loaded++;
                    if (loaded == ROUNDS) exp_done = c + 1;
                end
            end else begin
                checks++; if (reg_en !== 1'b0) begin errors++; $display("FAIL perm_extra_en: got %b expected 0", reg_en); end
            end
            if (done) done_cyc = c;
        end
        rnd_valid = 1'b0;
        checks++; if (pulses != ROUNDS) begin errors++; $display("FAIL perm_pulses: got %0d expected %0d", pulses, ROUNDS); end
        checks++; if (done_cyc != exp_done) begin errors++; $display("FAIL perm_done_cycle: got %0d expected %0d", done_cyc, exp_done); end
        if (use_pat) begin
            checks++; if (done_cyc != ROUNDS + (hi - lo + 1) + 1) begin errors++; $display("FAIL perm_latency: got %0d expected %0d", done_cyc, ROUNDS + (hi - lo + 1) + 1); end
        end
    endtask

    task automatic test_squeeze(input logic [3:0] len, input bit alt);
        int n = (int'(len) > NW) ? NW : int'(len);
        int rd = 0;
        bit done_seen = 0, prev_stall = 0;
        logic [63:0] prev_dout = '0;
        for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
        issue(2'd3, len, 32'd0, 1'b0);
        for (int c = 0; c < 200 && !done_seen; c++) begin
            @(negedge clk);
            dout_ready = alt ? (c % 2 == 1) : 1'($urandom_range(0, 1));
            #1;
            checks++; if ($countones({reg_init, reg_en, reg_word_en, reg_dom_en}) != 0) begin errors++; $display("FAIL sq_strobe: got %b expected 0000", {reg_init, reg_en, reg_word_en, reg_dom_en}); end
            if (prev_stall) begin
                checks++; if (dout !== prev_dout || dout_valid !== 1'b1) begin errors++; $display("FAIL sq_stable: got %h expected %h", dout, prev_dout); end
            end
            if (!done && rd < n) begin
                checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL sq_valid: got %b expected 1", dout_valid); end
            end
            if (dout_valid && dout_ready) begin
                checks++; if (rd >= n || dout !== mem[rd]) begin errors++; $display("FAIL sq_word: got %h expected %h (word %0d of %0d)", dout, mem[rd % 16], rd, n); end
                rd++;
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            if (done) done_seen = 1;
        end
        dout_ready = 1'b0;
        checks++; if (rd != n) begin errors++; $display("FAIL sq_count: got %0d expected %0d", rd, n); end
        checks++; if (!done_seen) begin errors++; $display("FAIL sq_done: got 0 expected 1"); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL sq_valid_after: got %b expected 0", dout_valid); end
    endtask

    task automatic test_reset_mid_perm;
        int pulses = 0;
        bit hit = 0;
        issue(2'd2, 4'd0, 32'd0, 1'b0);
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk); rnd_valid = 1'b1; #1;
            if (round_idx == 4'd5 && reg_en) hit = 1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL rst_reach_round5: got 0 expected 1"); end
        rst = 1'b0;
        #1;
        checks++; if ({reg_en, busy, done, round_idx} !== 7'd0) begin errors++; $display("FAIL rst_async_outputs: got %b expected 0", {reg_en, busy, done, round_idx}); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b expected 1", cmd_ready); end
        @(negedge clk); rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (reg_en || busy) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rst_no_resume: got %0d active cycles expected 0", pulses); end
        issue(2'd2, 4'd0, 32'd0, 1'b0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (reg_en) pulses++;
        end
        rnd_valid = 1'b0;
        checks++; if (pulses != ROUNDS) begin errors++; $display("FAIL rst_new_perm: got %0d expected %0d", pulses, ROUNDS); end
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_domain = '0;
        cmd_dom_en = 1'b0; din_valid = 1'b0; din = '0; dout_ready = 1'b0; rnd_valid = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset;
        test_init;
        test_absorb(4'd3, 1'b1, 32'h0000_0003, 1'b1, 16'hFFFD, 1'b0);
        test_absorb(4'd15, 1'b0, 32'h0, 1'b0, 16'h0, 1'b1);
        test_absorb(4'd12, 1'b1, $urandom, 1'b0, 16'h0, 1'b0);
        test_absorb(4'd0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0);
        test_absorb(4'($urandom_range(1, 11)), 1'($urandom_range(0, 1)), $urandom, 1'b0, 16'h0, 1'b1);
        test_permute(1'b1, 4, 6);
        test_permute(1'b0, 0, 0);
        test_permute(1'b0, 0, 0);
        test_squeeze(4'd12, 1'b1);
        test_squeeze(4'd5, 1'b0);
        test_squeeze(4'd0, 1'b0);
        test_squeeze(4'd14, 1'b0);
        test_reset_mid_perm;
        test_init;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
